ref_shallow_fifo_ctrl: RTL and testbench
========================================

Name: ref_shallow_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives the write and read ports of an external distributed-RAM instance, with FAST_READ=0 semantics.
- RAM read timing it must match: read address is registered, and read data is combinational from that registered address, so data is valid one cycle after the address is presented.
- Presents valid/ready streaming interfaces on both sides.
- Guarantees it never reads a RAM word in the cycle after that word was written.
- Used in the DMA datapath as a small elastic buffer (descriptor/credit queues).

Parameters:
- ADDR_WIDTH, 5, RAM address bits; RAM depth NUM_WORDS = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width.

Ports:
- clk  in  1  sole clock; RAM wr_clk and rd_clk both tie to it.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts the word this cycle.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  out_data holds the head word.
- out_ready  in  1  consumer takes the head word.
- out_data  out  DATA_WIDTH  head word, registered.
- level  out  ADDR_WIDTH+2  words accepted and not yet popped.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address, presented one cycle before data is used.
- ram_rd_data  in  DATA_WIDTH  RAM read data.

Behaviour:
- Pointers
  - wr_ptr and rd_ptr, ADDR_WIDTH+1 bits each, with the MSB as wrap bit.
  - ram_full when wr_ptr[MSB] != rd_ptr[MSB] and the low bits are equal.
- Push
  - in_ready = !ram_full && !rst.
  - Push condition: in_valid & in_ready.
  - On push: ram_wr_en=1, ram_wr_addr=wr_ptr[ADDR_WIDTH-1:0], ram_wr_data=in_data (combinational), wr_ptr++ at the clock edge.
  - in_ready ignores same-cycle pops: no write-through when full.
- Visibility
  - wr_vis is a register loaded with wr_ptr each cycle.
  - A word is fetchable only when rd_ptr != wr_vis.
  - This prevents the write-then-read collision.
- Fetch
  - ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0] continuously.
  - Fetch when fetchable && (occ + pend - pop) < 2.
    - occ: output buffer occupancy, 0..2.
    - pend: a fetch was issued in the previous cycle.
    - pop: out_valid & out_ready.
  - On fetch: rd_ptr++ and pend<=1; otherwise pend<=0.
  - When pend=1, ram_rd_data is valid that cycle and is written into the output buffer at the edge.
- Output buffer
  - 2-entry, in-order; head drives out_data/out_valid from registers.
  - Simultaneous pop and load: both applied, so occupancy is unchanged.
  - Load never finds the buffer full; this is guaranteed by the fetch rule.
  - Sustains 1 word/cycle when out_ready is held high.
- Latency
  - Push in cycle W into an empty FIFO: fetch at W+1, data at W+2, out_valid=1 at W+3.
- Level
  - level = (wr_ptr - rd_ptr) mod 2^(ADDR_WIDTH+1), plus pend, plus occ.
  - Registered, updated every cycle.
  - Maximum value is NUM_WORDS+2.
- Reset (async, also mid-operation)
  - Clears wr_ptr, rd_ptr, wr_vis, pend and occ.
  - Reset values: in_ready=0 while rst is high, out_valid=0, out_data=0, level=0, ram_wr_en=0, ram_rd_addr=0.
  - In-flight data is discarded; RAM contents are not cleared.
  - After rst deasserts, in_ready=1 combinationally.
- Protocol rule: out_data must stay stable while out_valid && !out_ready.
- Pointer wrap-around is natural modulo 2^(ADDR_WIDTH+1), with no special case.

Decomposition:
- No package required.
- Local constant: NUM_WORDS = 1 << ADDR_WIDTH.
- Level width (ADDR_WIDTH+2) is derived locally.
- One sub-module: ref_fifo_out_buf, the 2-entry registered output buffer.
  - Inputs: load, load_data, pop.
  - Outputs: occ, head valid, head data.
- The RAM is instantiated by the parent wrapper, not inside this block.

Test Plan:
- Use ADDR_WIDTH=2 and a behavioural RAM model that outputs X on same-address read in the cycle after a write.
- Single word: push 0xA5 at cycle 10 into an empty FIFO -> out_valid rises at cycle 13 with out_data=0xA5; level is 1 from cycle 11 through the pop cycle; no X is ever seen.
- Fill: out_ready=0, push 0..7 back-to-back -> in_ready drops after 6 accepts (4 RAM + 2 buffer); level=6; then drain with out_ready=1 -> 0..5 emitted in order, 1 per cycle.
- Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing pattern -> after a 3-cycle fill, out_valid is held high, one word per cycle, order intact, pointers wrap without error.
- Backpressure: random out_ready at 30% -> out_data is stable while stalled, no loss or duplication, level always equals the scoreboard count.
- Full plus pop: FIFO at level 6, in_valid=1, out_ready=1 -> in_ready stays 0 in the pop cycle; a push is accepted once rd_ptr frees a RAM slot.
- Reset mid-stream: assert rst asynchronously while level=4 -> out_valid, level and in_ready go to 0 immediately; after release, push 0x3C -> out_data=0x3C three cycles later with no stale words.

Source files
------------

// File: rtl/ref_fifo_out_buf.sv
// Two-entry in-order output register stage for the shallow FIFO controller.
// The head entry drives the consumer interface directly from flops.
module ref_fifo_out_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({load, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = load_data;
                else               tail_d = load_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Pop and load together keep occupancy; the new word lands behind any survivor.
                if (occ_q == 2'd1) begin
                    head_d = load_data;
                end else begin
                    head_d = tail_q;
                    tail_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ        = occ_q;
    assign head_valid = (occ_q != 2'd0);
    assign head_data  = head_q;

endmodule

// File: rtl/ref_shallow_fifo_ctrl.sv
// Single-clock FIFO controller driving an external distributed RAM whose read
// address is registered; a two-entry output buffer hides the read latency.
module ref_shallow_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int NUM_WORDS = 1 << ADDR_WIDTH;
    localparam int LVL_W     = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // Both streams: a word moves on a cycle where valid and ready are both high;
    // valid never waits on ready, and out_data holds while out_valid && !out_ready.

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] wr_vis_q;
    logic                pend_q, pend_d;
    logic [LVL_W-1:0]    level_q, level_d;

    logic                ram_full;
    logic                push;
    logic                pop;
    logic                fetchable;
    logic                fetch;
    logic [2:0]          buf_need;
    logic [1:0]          occ;
    logic [1:0]          occ_d;
    logic [ADDR_WIDTH:0] ptr_diff;

    assign ram_full = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign in_ready = !ram_full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // wr_vis trails the written words by one edge, so a word is never fetched in its write cycle.
    assign fetchable = (rd_ptr_q != wr_vis_q);
    assign buf_need  = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    assign fetch     = fetchable && (buf_need < 3'd2);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = 1'b0;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            pend_d   = 1'b1;
        end
        occ_d    = occ + {1'b0, pend_q} - {1'b0, pop};
        ptr_diff = wr_ptr_d - rd_ptr_d;
        level_d  = {1'b0, ptr_diff} + LVL_W'(pend_d) + LVL_W'(occ_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
            pend_q   <= 1'b0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_vis_q <= wr_ptr_d;
            pend_q   <= pend_d;
            level_q  <= level_d;
        end
    end

    ref_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_q),
        .load_data  (ram_rd_data),
        .pop        (pop),
        .occ        (occ),
        .head_valid (out_valid),
        .head_data  (out_data)
    );

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign level       = level_q;

    level_bound: assert property (@(posedge clk) disable iff (rst)
        level_q <= LVL_W'(NUM_WORDS + 2));

endmodule

// File: tb/tb_ref_shallow_fifo_ctrl.sv
// Directed bench for ref_shallow_fifo_ctrl with a collision-poisoning RAM model
// and a queue scoreboard watching every transfer.
module tb_ref_shallow_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ref_shallow_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    // RAM model: registered read address; X when reading the word written at the same edge.
    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] rd_addr_r = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic          last_wr_en = 1'b0;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        rd_addr_r    <= ram_rd_addr;
        last_wr_en   <= ram_wr_en;
        last_wr_addr <= ram_wr_addr;
    end

    assign ram_rd_data = (last_wr_en && last_wr_addr == rd_addr_r) ? 'x : mem[rd_addr_r];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard
    logic [DW-1:0] exp_q[$];
    int            model_level = 0;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data   = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("level", 32'(level), model_level);
            if (out_valid) check_eq("out_known", 32'($isunknown(out_data)), 32'd0);
            if (out_valid && prev_stall) check_eq("stable", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("order", 32'(out_data), 32'(exp_q.pop_front()));
                model_level--;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                model_level++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic drain(input int cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
        sample();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_level", 32'(level), 32'd0);
        check_eq("drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word: out_valid three cycles after the push cycle
        tick();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        sample();
        check_eq("sw_accept", 32'(in_ready), 32'd1);
        check_eq("sw_wr_en", 32'(ram_wr_en), 32'd1);
        check_eq("sw_wr_addr", 32'(ram_wr_addr), 32'd0);
        check_eq("sw_wr_data", 32'(ram_wr_data), 32'hA5);
        tick();
        in_valid = 1'b0;
        sample();
        check_eq("sw_w1_valid", 32'(out_valid), 32'd0);
        check_eq("sw_w1_level", 32'(level), 32'd1);
        check_eq("sw_w1_rd_addr", 32'(ram_rd_addr), 32'd0);
        tick();
        sample();
        check_eq("sw_w2_valid", 32'(out_valid), 32'd0);
        check_eq("sw_w2_level", 32'(level), 32'd1);
        tick();
        sample();
        check_eq("sw_w3_valid", 32'(out_valid), 32'd1);
        check_eq("sw_w3_data", 32'(out_data), 32'hA5);
        check_eq("sw_w3_level", 32'(level), 32'd1);
        tick();
        sample();
        check_eq("sw_w4_valid", 32'(out_valid), 32'd0);
        check_eq("sw_w4_level", 32'(level), 32'd0);

        // Fill with consumer stalled: 4 RAM words plus 2 buffered
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            in_valid = 1'b1; in_data = 8'(k);
            sample();
            check_eq("fill_ready", 32'(in_ready), 32'(k < 6));
        end
        tick();
        in_valid = 1'b0;
        sample();
        check_eq("fill_level", 32'(level), 32'd6);

        // Full plus pop: no write-through in the pop cycle, slot frees one cycle later
        tick();
        in_valid = 1'b1; in_data = 8'd6; out_ready = 1'b1;
        sample();
        check_eq("fp_ready_pop", 32'(in_ready), 32'd0);
        check_eq("fp_valid0", 32'(out_valid), 32'd1);
        tick();
        sample();
        check_eq("fp_ready_next", 32'(in_ready), 32'd1);
        check_eq("fp_valid1", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 2; k < 7; k++) begin
            sample();
            check_eq("fp_stream_valid", 32'(out_valid), 32'd1);
            tick();
        end
        drain(6);

        // Streaming: one word per cycle after the 3-cycle fill
        for (int k = 0; k < 100; k++) begin
            tick();
            in_valid = 1'b1; in_data = 8'(k + 8'h40); out_ready = 1'b1;
            sample();
            check_eq("st_ready", 32'(in_ready), 32'd1);
            if (k >= 3) check_eq("st_valid", 32'(out_valid), 32'd1);
        end
        drain(8);

        // Random backpressure
        for (int k = 0; k < 200; k++) begin
            tick();
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 9) < 3);
        end
        drain(20);

        // Reset mid-stream at level 4
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            in_valid = 1'b1; in_data = 8'(8'h90 + k);
        end
        tick();
        in_valid = 1'b0;
        sample();
        check_eq("mid_level", 32'(level), 32'd4);
        tick();
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_level", 32'(level), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        model_level = 0;
        prev_stall  = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_eq("mid_rel_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        sample();
        check_eq("mid_w1_valid", 32'(out_valid), 32'd0);
        tick();
        sample();
        check_eq("mid_w2_valid", 32'(out_valid), 32'd0);
        tick();
        sample();
        check_eq("mid_w3_valid", 32'(out_valid), 32'd1);
        check_eq("mid_w3_data", 32'(out_data), 32'h3C);
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
